dragon_head_ctrl: RTL
=====================

# dragon_head_ctrl

Upstream stage of the dragon body queue. On each divided game tick it moves the dragon head one grid cell toward the player. It then issues a one-cycle command (MOVE, HEAL or HIT) together with the new 10-bit orientation-and-position word, which the body queue enqueues. Heal and hit requests from game logic are latched here, merged with the body length reported back by the queue, and turned into the single command the queue requires.

## Interface
Parameters:
- STEP_DIV, 1: number of accepted `move_tick` pulses per head step (1..15).
- START_X, 8: head X after reset (0..15).
- START_Y, 8: head Y after reset (0..15).
- START_ORIEN, 2'b01: head orientation after reset.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- move_tick  in  1  game-step pulse, one cycle wide.
- player_pos  in  8  player position as {x[7:4], y[3:0]}.
- heal_req  in  1  pulse: the dragon ate; grow by one segment.
- hit_req  in  1  pulse: the dragon was struck; shrink by one segment.
- dragon_len  in  3  current body length, i.e. the queue's tail pointer.
- States  out  2  command to the queue: 00 MOVE, 01 HEAL, 10 HIT, 11 IDLE. Non-IDLE values last exactly one cycle.
- OrienAndPositon  out  10  {orien[9:8], x[7:4], y[3:0]}. Orientation codes: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).

## Operation
FSM states:
- WAIT: idle.
  - On `move_tick`, if div_cnt == STEP_DIV-1: clear div_cnt and go to CALC.
  - Otherwise, on `move_tick`: increment div_cnt and stay in WAIT.
  - With no `move_tick`: stay in WAIT.
- CALC:
  - Sample `player_pos` and `dragon_len`.
  - Compute dx = px - hx and dy = py - hy as 5-bit signed values.
  - Register the next head position and the command.
  - Go to EMIT.
- EMIT:
  - Drive the registered command on `States` for this one cycle.
  - Return to WAIT.

Step selection, in priority order:
- dx == 0 and dy == 0: no step. Command is IDLE; position and orientation are unchanged.
- |dx| >= |dy|: step along X by sign(dx). Orientation becomes 01 for positive dx, 11 for negative dx.
- Otherwise: step along Y by sign(dy). Orientation becomes 10 for positive dy, 00 for negative dy.
- Results are clamped to 0..15. No wrap-around. Clamping can never engage with legal inputs, but it is still required.

Pending request flags:
- heal_p is set by `heal_req`; hit_p is set by `hit_req`.
- Both hold until consumed in CALC.
- A request asserted in the CALC cycle itself counts for that step (flag OR input).
- A request asserted in EMIT counts for the next step.

Command selection on a real step (eff_heal = heal_p|heal_req, eff_hit = hit_p|hit_req):
- eff_heal and eff_hit: MOVE; both flags cleared (the requests cancel).
- eff_hit only: HIT if dragon_len != 0, else MOVE. hit_p cleared.
- eff_heal only: HEAL if dragon_len != 7, else MOVE. heal_p cleared.
- Neither: MOVE.

No-step case (head already on the player): command is IDLE and both flags are retained.

`move_tick` in CALC or EMIT is ignored and does not advance div_cnt.

## Timing
- Reset values:
  - FSM state = WAIT, div_cnt = 0, heal_p = hit_p = 0.
  - `States` = 2'b11.
  - `OrienAndPositon` = {START_ORIEN, START_X, START_Y}.
- Reset applied mid-operation (in CALC or EMIT) aborts the step: no pulse is issued, and all state returns to its reset values on the next edge.
- Latency: with `move_tick` high in cycle N and the divider expiring, the FSM is in CALC in cycle N+1. `States` carries the command in cycle N+2 only and returns to 11 in cycle N+3.
- `OrienAndPositon` updates in the same cycle as the `States` pulse (N+2) and holds between steps, so the queue can sample the pair on the same edge.
- Minimum spacing between two steps is 3 cycles (WAIT→CALC→EMIT).
- `player_pos` and `dragon_len` are only sampled in CALC.

## Test plan
- Reset with default parameters:
  - Expect `States`=11 and `OrienAndPositon`=0x188, held until the first tick.
- Player (12,9), tick in cycle N:
  - Expect `States`=00 in N+2 only and `OrienAndPositon`=0x198 (right, x=9, y=8).
  - Expect `States`=11 in N+3.
- Player (8,3) from reset:
  - Expect a Y step up: `OrienAndPositon`=0x087.
  - Tie case, player (10,10): expect an X step, 0x198.
- Heal and hit handling:
  - heal_req pulse, tick, dragon_len=3: expect `States`=01.
  - Same with dragon_len=7: expect `States`=00.
  - hit_req pulse with dragon_len=0: expect `States`=00 and hit_p cleared.
  - heal_req and hit_req in the same cycle: expect `States`=00 and both flags cleared.
- Head on the player (player 0x88), heal pending, tick:
  - Expect `States` to stay 11 and the word unchanged.
  - Move the player to (9,8) and tick: expect `States`=01.
- Divider and abort:
  - STEP_DIV=2: the first tick produces no output; the second tick produces a pulse.
  - Tick in CALC: ignored.
  - Reset asserted in CALC: no pulse, word returns to 0x188.

Source files
------------

// File: rtl/dragon_head_ctrl.sv
// Dragon head controller: steps the head one grid cell toward the player on each
// divided game tick and issues a one-cycle MOVE/HEAL/HIT command to the body queue.
module dragon_head_ctrl #(
  parameter int         STEP_DIV    = 1,
  parameter int         START_X     = 8,
  parameter int         START_Y     = 8,
  parameter logic [1:0] START_ORIEN = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [7:0] player_pos,
  input  logic       heal_req,
  input  logic       hit_req,
  input  logic [2:0] dragon_len,
  output logic [1:0] States,
  output logic [9:0] OrienAndPositon
);

  localparam logic [1:0] CMD_MOVE = 2'b00;
  localparam logic [1:0] CMD_HEAL = 2'b01;
  localparam logic [1:0] CMD_HIT  = 2'b10;
  localparam logic [1:0] CMD_IDLE = 2'b11;
  localparam logic [1:0] OR_UP    = 2'b00;
  localparam logic [1:0] OR_RIGHT = 2'b01;
  localparam logic [1:0] OR_DOWN  = 2'b10;
  localparam logic [1:0] OR_LEFT  = 2'b11;
  localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);
  localparam logic [9:0] WORD_RST = {START_ORIEN, 4'(START_X), 4'(START_Y)};

  typedef enum logic [1:0] {WAIT, CALC, EMIT} state_t;

  state_t            state, state_nxt;
  logic [3:0]        div_cnt, div_nxt;
  logic              heal_p, hit_p, heal_nxt, hit_nxt;
  logic [1:0]        st_nxt;
  logic [9:0]        word_nxt;
  logic [1:0]        cmd;
  logic signed [4:0] dx, dy;
  logic [4:0]        adx, ady;
  logic              eff_heal, eff_hit, no_step;

  // One grid step with the result pinned to the 0..15 board.
  function automatic logic [3:0] step_clamp(input logic [3:0] c, input logic dec);
    logic signed [5:0] t;
    t = $signed({2'b00, c}) + (dec ? -6'sd1 : 6'sd1);
    if (t < 6'sd0)  return 4'd0;
    if (t > 6'sd15) return 4'd15;
    return t[3:0];
  endfunction

  function automatic logic [4:0] abs5(input logic signed [4:0] v);
    return v[4] ? 5'(-v) : 5'(v);
  endfunction

  assign dx       = $signed({1'b0, player_pos[7:4]}) - $signed({1'b0, OrienAndPositon[7:4]});
  assign dy       = $signed({1'b0, player_pos[3:0]}) - $signed({1'b0, OrienAndPositon[3:0]});
  assign adx      = abs5(dx);
  assign ady      = abs5(dy);
  assign eff_heal = heal_p | heal_req;
  assign eff_hit  = hit_p | hit_req;
  assign no_step  = (dx == 5'sd0) && (dy == 5'sd0);

  always_comb begin
    if (eff_heal && eff_hit)  cmd = CMD_MOVE;
    else if (eff_hit)         cmd = (dragon_len != 3'd0) ? CMD_HIT : CMD_MOVE;
    else if (eff_heal)        cmd = (dragon_len != 3'd7) ? CMD_HEAL : CMD_MOVE;
    else                      cmd = CMD_MOVE;
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    heal_nxt  = eff_heal;
    hit_nxt   = eff_hit;
    st_nxt    = CMD_IDLE;
    word_nxt  = OrienAndPositon;
    case (state)
      WAIT: begin
        if (move_tick) begin
          if (div_cnt == DIV_LAST) begin
            div_nxt   = 4'd0;
            state_nxt = CALC;
          end else begin
            div_nxt = div_cnt + 4'd1;
          end
        end
      end
      CALC: begin
        state_nxt = EMIT;
        // Head already on the player: no command, requests stay pending.
        if (!no_step) begin
          st_nxt   = cmd;
          heal_nxt = 1'b0;
          hit_nxt  = 1'b0;
          if (adx >= ady)
            word_nxt = {dx[4] ? OR_LEFT : OR_RIGHT,
                        step_clamp(OrienAndPositon[7:4], dx[4]), OrienAndPositon[3:0]};
          else
            word_nxt = {dy[4] ? OR_UP : OR_DOWN,
                        OrienAndPositon[7:4], step_clamp(OrienAndPositon[3:0], dy[4])};
        end
      end
      EMIT:    state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT;
      div_cnt         <= 4'd0;
      heal_p          <= 1'b0;
      hit_p           <= 1'b0;
      States          <= CMD_IDLE;
      OrienAndPositon <= WORD_RST;
    end else begin
      state           <= state_nxt;
      div_cnt         <= div_nxt;
      heal_p          <= heal_nxt;
      hit_p           <= hit_nxt;
      States          <= st_nxt;
      OrienAndPositon <= word_nxt;
    end
  end

endmodule
